mosfet_deadtime_driver: RTL and testbench

- Downstream consumer of the 4-bit MOSFET command bus produced by the hybrid controller.
- Splits the command into two half-bridge legs: leg A = {gate0 high-side, gate2 low-side}, leg B = {gate1 high-side, gate3 low-side}.
- Per leg, inserts a programmable dead time on every commutation, blocks shoot-through and latches a fault on illegal commands.
- Drives the physical gate pins and exposes a commutation counter for debug.

---
 rtl/mosfet_deadtime_driver.sv | 149 ++++++++++++++
 tb/tb_mosfet_deadtime_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mosfet_deadtime_driver.sv
// Two-leg half-bridge gate driver with per-leg dead-time insertion.
// Takes the 4-bit MOSFET command bus, registers it, and runs one small FSM per
// leg (A = gate0 high / gate2 low, B = gate1 high / gate3 low) that inserts
// DEAD_TIME cycles of both-off on every commutation. A command with high and
// low asserted on the same leg latches a fault and forces both legs off.
//
// Ports:
//   i_clock        system clock
//   i_RESET        asynchronous, active-low reset
//   i_MOSFET       raw gate commands {B lo, A lo, B hi, A hi}
//   i_enable       1 = gating allowed, 0 = all gates off (dead time honoured)
//   i_clear_fault  single-cycle pulse clearing a latched fault
//   o_gate         gate drive, same bit mapping as i_MOSFET
//   o_fault        latched shoot-through-command fault
//   o_switch_count completed dead-time intervals, both legs summed
//   o_debug        {legB_state, legA_state, legB_dt, legA_dt, inv_B, inv_A}
module mosfet_deadtime_driver #(
    parameter int unsigned DEAD_TIME = 25,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_clock,
    input  logic             i_RESET,
    input  logic [3:0]       i_MOSFET,
    input  logic             i_enable,
    input  logic             i_clear_fault,
    output logic [3:0]       o_gate,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_switch_count,
    output logic [7:0]       o_debug
);

    localparam int unsigned DT_W = 8;
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD_TIME - 1);

    typedef enum logic [1:0] {
        ST_OFF = 2'b00,
        ST_HI  = 2'b01,
        ST_LO  = 2'b10,
        ST_DT  = 2'b11
    } leg_state_e;

    typedef struct packed {
        leg_state_e      state;
        logic [DT_W-1:0] cnt;
        logic            done;
    } leg_next_t;

    logic [3:0]       cmd_q;
    logic             fault_q, fault_d;
    leg_state_e       state_a_q, state_b_q;
    logic [DT_W-1:0]  cnt_a_q, cnt_b_q;
    logic [CNT_W-1:0] count_q, count_d;
    leg_next_t        next_a, next_b;
    logic             inv_a, inv_b, block;
    leg_state_e       tgt_a, tgt_b;

    // Leg state the current command asks for; blocked legs are sent off.
    function automatic leg_state_e leg_target(input logic hi, input logic lo,
                                              input logic blk);
        if (blk)            return ST_OFF;
        else if (hi && !lo) return ST_HI;
        else if (lo && !hi) return ST_LO;
        else                return ST_OFF;
    endfunction

    // One leg's transition: on-states leave through DT, DT resolves to the
    // command present when the countdown expires.
    function automatic leg_next_t leg_next(input leg_state_e st,
                                           input logic [DT_W-1:0] cnt,
                                           input leg_state_e tgt);
        leg_next_t n;
        n.state = st;
        n.cnt   = cnt;
        n.done  = 1'b0;
        case (st)
            ST_OFF: n.state = tgt;
            ST_HI, ST_LO: begin
                if (tgt != st) begin
                    n.state = ST_DT;
                    n.cnt   = DT_LOAD;
                end
            end
            ST_DT: begin
                if (cnt == '0) begin
                    n.state = tgt;
                    n.done  = 1'b1;
                end else begin
                    n.cnt = cnt - DT_W'(1);
                end
            end
            default: n.state = ST_OFF;
        endcase
        return n;
    endfunction

    assign inv_a = cmd_q[0] & cmd_q[2];
    assign inv_b = cmd_q[1] & cmd_q[3];
    // An invalid command blocks on-states in the same cycle it is seen,
    // one cycle before the latched fault flag catches up.
    assign block = ~i_enable | fault_q | inv_a | inv_b;
    assign tgt_a = leg_target(cmd_q[0], cmd_q[2], block);
    assign tgt_b = leg_target(cmd_q[1], cmd_q[3], block);

    // State register
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            cmd_q     <= '0;
            fault_q   <= 1'b0;
            state_a_q <= ST_OFF;
            state_b_q <= ST_OFF;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            count_q   <= '0;
        end else begin
            cmd_q     <= i_MOSFET;
            fault_q   <= fault_d;
            state_a_q <= next_a.state;
            state_b_q <= next_b.state;
            cnt_a_q   <= next_a.cnt;
            cnt_b_q   <= next_b.cnt;
            count_q   <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        next_a  = leg_next(state_a_q, cnt_a_q, tgt_a);
        next_b  = leg_next(state_b_q, cnt_b_q, tgt_b);
        fault_d = fault_q;
        // A fresh invalid command wins over a simultaneous clear.
        if (inv_a || inv_b) begin
            fault_d = 1'b1;
        end else if (i_clear_fault) begin
            fault_d = 1'b0;
        end
        count_d = count_q + CNT_W'(next_a.done) + CNT_W'(next_b.done);
    end

    // Outputs decoded from registered state only
    always_comb begin
        o_gate         = {state_b_q == ST_LO, state_a_q == ST_LO,
                          state_b_q == ST_HI, state_a_q == ST_HI};
        o_fault        = fault_q;
        o_switch_count = count_q;
        o_debug        = {state_b_q, state_a_q, state_b_q == ST_DT,
                          state_a_q == ST_DT, inv_b, inv_a};
    end

endmodule

// File: tb/tb_mosfet_deadtime_driver.sv
// Bench for mosfet_deadtime_driver: directed scenarios plus a random phase,
// with a behavioural reference whose per-cycle predictions go through a queue.
module tb_mosfet_deadtime_driver;

    localparam int unsigned DT = 25;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    mosfet;
    logic          enable;
    logic          clear_fault;
    logic [3:0]    gate;
    logic          fault;
    logic [CW-1:0] count;
    logic [7:0]    debug;

    mosfet_deadtime_driver #(.DEAD_TIME(DT), .CNT_W(CW)) dut (
        .i_clock        (clk),
        .i_RESET        (rst_n),
        .i_MOSFET       (mosfet),
        .i_enable       (enable),
        .i_clear_fault  (clear_fault),
        .o_gate         (gate),
        .o_fault        (fault),
        .o_switch_count (count),
        .o_debug        (debug)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    gate;
        logic          fault;
        logic [CW-1:0] cnt;
        logic [7:0]    debug;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference: leg state 0 = off, 1 = high on, 2 = low on, 3 = dead window
    int            m_st [2];
    int            m_rem[2];
    logic [3:0]    m_cmd;
    logic          m_fault;
    logic [CW-1:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            m_st[l]  = 0;
            m_rem[l] = 0;
        end
        m_cmd   = 4'b0000;
        m_fault = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic model_step(input logic [3:0] cmd, input logic en,
                              input logic clr);
        logic inv;
        logic allow;
        logic hi, lo;
        int   want;
        inv   = (m_cmd[0] && m_cmd[2]) || (m_cmd[1] && m_cmd[3]);
        allow = en && !m_fault && !inv;
        for (int l = 0; l < 2; l++) begin
            hi = m_cmd[l];
            lo = m_cmd[l+2];
            if (!allow)         want = 0;
            else if (hi && !lo) want = 1;
            else if (lo && !hi) want = 2;
            else                want = 0;
            case (m_st[l])
                0: m_st[l] = want;
                1, 2: if (want != m_st[l]) begin
                    m_st[l]  = 3;
                    m_rem[l] = int'(DT) - 1;
                end
                default: if (m_rem[l] == 0) begin
                    m_st[l] = want;
                    m_cnt   = m_cnt + 1'b1;
                end else begin
                    m_rem[l] = m_rem[l] - 1;
                end
            endcase
        end
        if (inv)      m_fault = 1'b1;
        else if (clr) m_fault = 1'b0;
        m_cmd = cmd;
    endtask

    // Predict the post-edge outputs, advance one clock, compare.
    task automatic tick();
        exp_t e;
        exp_t got;
        model_step(mosfet, enable, clear_fault);
        e.gate  = {m_st[1] == 2, m_st[0] == 2, m_st[1] == 1, m_st[0] == 1};
        e.fault = m_fault;
        e.cnt   = m_cnt;
        e.debug = {2'(m_st[1]), 2'(m_st[0]), m_st[1] == 3, m_st[0] == 3,
                   m_cmd[1] & m_cmd[3], m_cmd[0] & m_cmd[2]};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_eq("gate",  32'(gate),  32'(got.gate));
        check_eq("fault", 32'(fault), 32'(got.fault));
        check_eq("count", 32'(count), 32'(got.cnt));
        check_eq("debug", 32'(debug), 32'(got.debug));
        check_eq("no_shoot", 32'({gate[3] & gate[1], gate[2] & gate[0]}), 32'(0));
    endtask

    int            zeros;
    logic          held;
    logic          seen;
    logic [CW-1:0] base;
    int            hold;

    initial begin
        rst_n       = 1'b0;
        mosfet      = 4'b0000;
        enable      = 1'b0;
        clear_fault = 1'b0;
        model_reset();
        #12;
        check_eq("rst_gate",  32'(gate),  32'(0));
        check_eq("rst_fault", 32'(fault), 32'(0));
        check_eq("rst_count", 32'(count), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Plain turn-on: two edges from command to gate
        enable = 1'b1;
        mosfet = 4'b1001;
        tick();
        check_eq("lat_edge1", 32'(gate), 32'(0));
        tick();
        check_eq("lat_edge2", 32'(gate), 32'(4'b1001));
        repeat (3) tick();

        // Full reversal on both legs
        mosfet = 4'b0110;
        zeros  = 0;
        repeat (30) begin
            tick();
            if (gate == 4'b0000) zeros++;
        end
        check_eq("rev_dead_len", 32'(zeros), 32'(DT));
        check_eq("rev_gate",     32'(gate),  32'(4'b0110));
        check_eq("rev_count",    32'(count), 32'(2));

        // Only leg B commutates; leg A high side stays on
        mosfet = 4'b1001;
        repeat (30) tick();
        mosfet = 4'b0011;
        zeros  = 0;
        held   = 1'b1;
        repeat (30) begin
            tick();
            if (!gate[1] && !gate[3]) zeros++;
            if (!gate[0]) held = 1'b0;
        end
        check_eq("legb_dead_len", 32'(zeros), 32'(DT));
        check_eq("lega_held",     32'(held),  32'(1));
        check_eq("legb_count",    32'(count), 32'(5));

        // Shoot-through command on leg A
        mosfet = 4'b0101;
        seen   = 1'b0;
        repeat (DT + 5) begin
            tick();
            if (gate[2]) seen = 1'b1;
        end
        check_eq("inv_fault",  32'(fault), 32'(1));
        check_eq("inv_gate",   32'(gate),  32'(0));
        check_eq("inv_no_lo",  32'(seen),  32'(0));
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check_eq("clr_blocked", 32'(fault), 32'(1));
        mosfet = 4'b1001;
        tick();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check_eq("clr_ok", 32'(fault), 32'(0));
        tick();
        check_eq("clr_gate", 32'(gate), 32'(4'b1001));
        repeat (3) tick();

        // Leg A flips to low and back inside the dead window
        base   = count;
        mosfet = 4'b1100;
        zeros  = 0;
        repeat (10) begin
            tick();
            if (!gate[0] && !gate[2]) zeros++;
        end
        mosfet = 4'b1001;
        repeat (30) begin
            tick();
            if (!gate[0] && !gate[2]) zeros++;
        end
        check_eq("tog_dead_len", 32'(zeros), 32'(DT));
        check_eq("tog_gate",     32'(gate),  32'(4'b1001));
        check_eq("tog_count",    32'(count - base), 32'(1));

        // Asynchronous reset in the middle of a dead window
        mosfet = 4'b0110;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_gate",  32'(gate),  32'(0));
        check_eq("mid_rst_count", 32'(count), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        mosfet = 4'b1001;
        repeat (3) tick();

        // Disable drops gates after one edge and parks in OFF
        enable = 1'b0;
        tick();
        check_eq("dis_gate", 32'(gate), 32'(0));
        repeat (30) tick();
        check_eq("dis_parked", 32'(debug[7:4]), 32'(0));
        enable = 1'b1;
        tick();
        check_eq("reen_gate", 32'(gate), 32'(4'b1001));

        // Random commands, enables and clear pulses
        for (int s = 0; s < 40; s++) begin
            mosfet      = 4'($urandom_range(0, 15));
            enable      = ($urandom_range(0, 7) != 0);
            clear_fault = ($urandom_range(0, 3) == 0);
            hold        = int'($urandom_range(1, 40));
            tick();
            clear_fault = 1'b0;
            repeat (hold) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
